mem_sram_ctrl: RTL and testbench
================================

// Module: mem_sram_ctrl
// PURPOSE
//  MEM-stage data-memory access unit: consumes the load/store request held in the EX/MEM register
//  (aluop, effective address, store operand) and performs one multi-cycle asynchronous-SRAM bus cycle.
//  Stalls the pipeline for the duration of the access, then returns the aligned, sign-extended load
//  data to the MEM/WB path. Non-memory instructions pass through with zero added latency.
// PARAMETERS
//  WAIT_CYCLES  1   SRAM access length in cycles; legal range 1..15. Strobes are held for this many cycles.
//  RAM_AW       20  SRAM word-address width. ram_addr_o = mem_addr_i[RAM_AW+1:2].
// PORTS
//  clk            in   1          system clock, all state updates on posedge
//  rst            in   1          synchronous, active-high reset (`RstEnable)
//  mem_aluop_i    in   `AluOpBus  op held in EX/MEM; memory ops: `EXE_LB_OP,`EXE_LW_OP,`EXE_SB_OP,`EXE_SW_OP
//  mem_addr_i     in   32         effective byte address
//  mem_reg2_i     in   32         store operand
//  mem_wd_i       in   5          destination register
//  mem_wreg_i     in   1          destination write enable
//  mem_wdata_i    in   32         ALU result (used by non-load ops)
//  wd_o           out  5          destination register to MEM/WB
//  wreg_o         out  1          write enable to MEM/WB
//  wdata_o        out  32         write data to MEM/WB
//  stallreq_o     out  1          stall request to the ctrl block (freezes stages 0..3)
//  ram_addr_o     out  RAM_AW     SRAM word address
//  ram_wdata_o    out  32         SRAM write data
//  ram_rdata_i    in   32         SRAM read data
//  ram_data_oe_o  out  1          1 = drive ram_wdata_o onto the shared data bus
//  ram_ce_n_o     out  1          chip enable, active low
//  ram_oe_n_o     out  1          output enable, active low
//  ram_we_n_o     out  1          write enable, active low
//  ram_be_n_o     out  4          byte enables, active low; bit i = byte lane i
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state->IDLE, wait counter=0, latched request and load data cleared.
//    While in reset: wd_o=`NOPRegAddr, wreg_o=0, wdata_o=0, stallreq_o=0, ram_ce_n/oe_n/we_n=1,
//    ram_be_n=4'hF, ram_addr=0, ram_wdata=0, ram_data_oe=0. A reset mid-access aborts it with no retry.
//  - FSM states: IDLE, ACCESS, DONE.
//    IDLE: non-memory op -> wd_o/wreg_o/wdata_o = inputs combinationally, stallreq_o=0.
//          memory op -> stallreq_o=1 combinationally, wreg_o=0. Latch op, address, data, wd and wreg.
//          Load counter with WAIT_CYCLES-1. Next state: ACCESS.
//    ACCESS: strobes driven from the latched request. stallreq_o=1, wreg_o=0.
//          Decrement the counter each cycle. At counter==0: a load samples ram_rdata_i at this
//          edge; next state: DONE.
//    DONE: stallreq_o=0. wd_o/wreg_o come from the latched values. wdata_o is the extracted load
//          data for loads and the latched mem_wdata for stores. Next state: IDLE unconditionally.
//          The pipeline advances at this edge, so the request is never re-issued.
//  - Stall length per memory op = WAIT_CYCLES+1 cycles. Result is visible in the DONE cycle.
//    Back-to-back memory ops: the second is detected in the IDLE cycle after DONE.
//  - Strobes in ACCESS: ram_ce_n=0.
//    Load: oe_n=0, we_n=1, data_oe=0, be_n=0000.
//    Store: oe_n=1, we_n=0, data_oe=1.
//  - LW/SW ignore addr[1:0] (word access). SW: be_n=0000, ram_wdata=reg2.
//  - SB: be_n has bit addr[1:0] cleared and all other bits set; ram_wdata={4{reg2[7:0]}}.
//  - LB: byte = rdata[8*addr[1:0]+7 -: 8], sign-extended to 32 bits. LW: rdata unchanged.
//  - Outside ACCESS all strobes are deasserted (1) and ram_data_oe=0. ram_addr/ram_wdata hold their last value.
// TESTING
//  1 WAIT=1, LW addr 0x80000104, rdata 0x12345678 -> ram_addr 0x00041, stallreq high 2 cycles, oe_n low 1 cycle, DONE wdata_o=0x12345678 wreg_o=1.
//  2 LB addr 0x...03, rdata 0x80AA5511 -> wdata_o=0xFFFFFF80. LB addr 0x...01 -> wdata_o=0x00000055.
//  3 SB addr 0x...01, reg2 0x000000AB -> be_n=4'b1101, ram_wdata=0xABABABAB, we_n low WAIT cycles, oe_n high.
//  4 ADDU, wdata 0x5, wd 3 -> passthrough in the same cycle, stallreq_o never asserted, all strobes stay 1.
//  5 WAIT=3, rst pulse in the 2nd ACCESS cycle -> next cycle all outputs at reset values, IDLE; the following LW runs normally.
//  6 SW then LW back-to-back (WAIT=2) -> two separate 3-cycle stalls, one IDLE cycle between them, correct data for each.

Source files
------------

// File: rtl/mem_sram_ctrl.sv
// MEM-stage data-memory access unit: runs one multi-cycle asynchronous SRAM bus cycle per
// load/store, stalls the pipeline for its duration and returns aligned, sign-extended load data.
module mem_sram_ctrl #(
  parameter int WAIT_CYCLES = 1,
  parameter int RAM_AW      = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        mem_aluop_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_reg2_i,
  input  logic [4:0]        mem_wd_i,
  input  logic              mem_wreg_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o,
  output logic              stallreq_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i,
  output logic              ram_data_oe_o,
  output logic              ram_ce_n_o,
  output logic              ram_oe_n_o,
  output logic              ram_we_n_o,
  output logic [3:0]        ram_be_n_o
);

  localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
  localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
  localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
  localparam logic [7:0] EXE_SW_OP  = 8'b11101011;
  localparam logic [4:0] NOP_REG    = 5'b00000;
  localparam logic [3:0] CNT_RELOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [7:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_reg2;
  logic [4:0]  r_wd;
  logic        r_wreg;
  logic [31:0] r_wdata;
  logic [31:0] r_ldata;

  logic        w_isMem;
  logic        w_opIsLoad;
  logic [7:0]  w_ldByte;
  logic        w_unused;

  assign w_isMem    = (mem_aluop_i == EXE_LB_OP) || (mem_aluop_i == EXE_LW_OP) ||
                      (mem_aluop_i == EXE_SB_OP) || (mem_aluop_i == EXE_SW_OP);
  assign w_opIsLoad = (r_op == EXE_LB_OP) || (r_op == EXE_LW_OP);
  assign w_unused   = ^r_addr[31:RAM_AW+2];

  always_comb begin
    w_ldByte = ram_rdata_i[7:0];
    case (r_addr[1:0])
      2'd0: w_ldByte = ram_rdata_i[7:0];
      2'd1: w_ldByte = ram_rdata_i[15:8];
      2'd2: w_ldByte = ram_rdata_i[23:16];
      2'd3: w_ldByte = ram_rdata_i[31:24];
      default: w_ldByte = ram_rdata_i[7:0];
    endcase
  end

  // Request is latched on entry so the bus cycle is immune to whatever the pipeline presents later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_op    <= 8'd0;
      r_addr  <= 32'd0;
      r_reg2  <= 32'd0;
      r_wd    <= NOP_REG;
      r_wreg  <= 1'b0;
      r_wdata <= 32'd0;
      r_ldata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_isMem) begin
            r_op    <= mem_aluop_i;
            r_addr  <= mem_addr_i;
            r_reg2  <= mem_reg2_i;
            r_wd    <= mem_wd_i;
            r_wreg  <= mem_wreg_i;
            r_wdata <= mem_wdata_i;
            r_cnt   <= CNT_RELOAD;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            if (r_op == EXE_LB_OP) begin
              r_ldata <= {{24{w_ldByte[7]}}, w_ldByte};
            end else if (r_op == EXE_LW_OP) begin
              r_ldata <= ram_rdata_i;
            end
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Non-memory ops bypass combinationally; reset overrides every output while asserted.
  always_comb begin
    wd_o          = NOP_REG;
    wreg_o        = 1'b0;
    wdata_o       = 32'd0;
    stallreq_o    = 1'b0;
    ram_ce_n_o    = 1'b1;
    ram_oe_n_o    = 1'b1;
    ram_we_n_o    = 1'b1;
    ram_be_n_o    = 4'hF;
    ram_data_oe_o = 1'b0;
    ram_addr_o    = r_addr[RAM_AW+1:2];
    ram_wdata_o   = (r_op == EXE_SB_OP) ? {4{r_reg2[7:0]}} : r_reg2;
    if (rst) begin
      ram_addr_o  = '0;
      ram_wdata_o = 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_isMem) begin
            stallreq_o = 1'b1;
          end else begin
            wd_o    = mem_wd_i;
            wreg_o  = mem_wreg_i;
            wdata_o = mem_wdata_i;
          end
        end
        S_ACCESS: begin
          stallreq_o = 1'b1;
          ram_ce_n_o = 1'b0;
          if (w_opIsLoad) begin
            ram_oe_n_o = 1'b0;
            ram_be_n_o = 4'h0;
          end else begin
            ram_we_n_o    = 1'b0;
            ram_data_oe_o = 1'b1;
            ram_be_n_o    = (r_op == EXE_SB_OP) ? ~(4'b0001 << r_addr[1:0]) : 4'h0;
          end
        end
        S_DONE: begin
          wd_o    = r_wd;
          wreg_o  = r_wreg;
          wdata_o = w_opIsLoad ? r_ldata : r_wdata;
        end
        default: begin
          stallreq_o = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl: three instances (WAIT_CYCLES 1..3) share stimulus,
// each scenario checks the instance whose timing it targets.
module tb_mem_sram_ctrl;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_ADDU = 8'b00100001;
  localparam logic [7:0] OP_LB   = 8'b11100000;
  localparam logic [7:0] OP_LW   = 8'b11100011;
  localparam logic [7:0] OP_SB   = 8'b11101000;
  localparam logic [7:0] OP_SW   = 8'b11101011;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop;
  logic [31:0] addr;
  logic [31:0] reg2;
  logic [4:0]  wd;
  logic        wreg;
  logic [31:0] wdata;
  logic [31:0] rdata;

  logic [4:0]  wdO[3];
  logic        wregO[3];
  logic [31:0] wdataO[3];
  logic        stallO[3];
  logic [19:0] ramAddrO[3];
  logic [31:0] ramWdataO[3];
  logic        dataOeO[3];
  logic        ceNO[3];
  logic        oeNO[3];
  logic        weNO[3];
  logic [3:0]  beNO[3];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gDut
    mem_sram_ctrl #(.WAIT_CYCLES(g + 1), .RAM_AW(20)) uDut (
      .clk(clk), .rst(rst),
      .mem_aluop_i(aluop), .mem_addr_i(addr), .mem_reg2_i(reg2),
      .mem_wd_i(wd), .mem_wreg_i(wreg), .mem_wdata_i(wdata),
      .wd_o(wdO[g]), .wreg_o(wregO[g]), .wdata_o(wdataO[g]), .stallreq_o(stallO[g]),
      .ram_addr_o(ramAddrO[g]), .ram_wdata_o(ramWdataO[g]), .ram_rdata_i(rdata),
      .ram_data_oe_o(dataOeO[g]), .ram_ce_n_o(ceNO[g]), .ram_oe_n_o(oeNO[g]),
      .ram_we_n_o(weNO[g]), .ram_be_n_o(beNO[g])
    );
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [7:0] op, input logic [31:0] a, input logic [31:0] r2,
                               input logic [4:0] d, input logic we, input logic [31:0] wdat,
                               input logic [31:0] rd);
    aluop = op; addr = a; reg2 = r2; wd = d; wreg = we; wdata = wdat; rdata = rd;
  endtask

  task automatic checkIdleBus(input int idx, input string tag);
    checkOutput({tag, " ce_n"}, ceNO[idx], 1);
    checkOutput({tag, " oe_n"}, oeNO[idx], 1);
    checkOutput({tag, " we_n"}, weNO[idx], 1);
    checkOutput({tag, " be_n"}, beNO[idx], 4'hF);
    checkOutput({tag, " data_oe"}, dataOeO[idx], 0);
  endtask

  // Reset with a memory op on the inputs: the outputs must still show reset values.
  task automatic resetAll(input int idx);
    rst = 1'b1;
    applyStimulus(OP_LW, 32'h12345678, 32'hFFFFFFFF, 5'd7, 1'b1, 32'h55, 32'h0);
    tick();
    tick();
    #1;
    checkOutput("rst stall", stallO[idx], 0);
    checkOutput("rst wd", wdO[idx], 0);
    checkOutput("rst wreg", wregO[idx], 0);
    checkOutput("rst wdata", wdataO[idx], 0);
    checkOutput("rst ram_addr", ramAddrO[idx], 0);
    checkOutput("rst ram_wdata", ramWdataO[idx], 0);
    checkIdleBus(idx, "rst");
    rst = 1'b0;
    applyStimulus(OP_NOP, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  // Starts in IDLE, ends in the DONE cycle with the request still on the inputs.
  task automatic runAccess(input int idx, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] r2, input logic [4:0] d, input logic we,
                           input logic [31:0] wdat, input logic [31:0] rd,
                           input logic [31:0] expWdata, input logic [3:0] expBe,
                           input logic [19:0] expRamAddr, input logic [31:0] expRamWdata);
    logic isLoad;
    isLoad = (op == OP_LB) || (op == OP_LW);
    applyStimulus(op, a, r2, d, we, wdat, rd);
    #1;
    checkOutput("idle stall", stallO[idx], 1);
    checkOutput("idle wreg", wregO[idx], 0);
    checkOutput("idle ce_n", ceNO[idx], 1);
    for (int c = 0; c < idx + 1; c++) begin
      tick();
      checkOutput("acc stall", stallO[idx], 1);
      checkOutput("acc wreg", wregO[idx], 0);
      checkOutput("acc ce_n", ceNO[idx], 0);
      checkOutput("acc oe_n", oeNO[idx], isLoad ? 1'b0 : 1'b1);
      checkOutput("acc we_n", weNO[idx], isLoad ? 1'b1 : 1'b0);
      checkOutput("acc data_oe", dataOeO[idx], !isLoad);
      checkOutput("acc be_n", beNO[idx], expBe);
      checkOutput("acc ram_addr", ramAddrO[idx], expRamAddr);
      if (!isLoad) checkOutput("acc ram_wdata", ramWdataO[idx], expRamWdata);
    end
    tick();
    checkOutput("done stall", stallO[idx], 0);
    checkOutput("done wd", wdO[idx], d);
    checkOutput("done wreg", wregO[idx], we);
    checkOutput("done wdata", wdataO[idx], expWdata);
    checkIdleBus(idx, "done");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(OP_NOP, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;

    resetAll(0);
    runAccess(0, OP_LW, 32'h80000104, 32'h0, 5'd7, 1'b1, 32'hDEAD, 32'h12345678,
              32'h12345678, 4'h0, 20'h00041, 32'h0);
    applyStimulus(OP_NOP, 0, 0, 0, 0, 0, 0);
    tick();

    runAccess(0, OP_LB, 32'h80000003, 32'h0, 5'd4, 1'b1, 32'h0, 32'h80AA5511,
              32'hFFFFFF80, 4'h0, 20'h00000, 32'h0);
    applyStimulus(OP_NOP, 0, 0, 0, 0, 0, 0);
    tick();
    runAccess(0, OP_LB, 32'h80000001, 32'h0, 5'd4, 1'b1, 32'h0, 32'h80AA5511,
              32'h00000055, 4'h0, 20'h00000, 32'h0);
    applyStimulus(OP_NOP, 0, 0, 0, 0, 0, 0);
    tick();

    runAccess(0, OP_SB, 32'h80000001, 32'h000000AB, 5'd0, 1'b0, 32'h80000001, 32'h0,
              32'h80000001, 4'b1101, 20'h00000, 32'hABABABAB);
    tick();

    applyStimulus(OP_ADDU, 32'h0, 32'h0, 5'd3, 1'b1, 32'h5, 32'h0);
    #1;
    checkOutput("addu wd", wdO[0], 3);
    checkOutput("addu wreg", wregO[0], 1);
    checkOutput("addu wdata", wdataO[0], 5);
    checkOutput("addu stall", stallO[0], 0);
    checkOutput("hold ram_wdata", ramWdataO[0], 32'hABABABAB);
    checkIdleBus(0, "addu");
    tick();
    checkOutput("addu stall2", stallO[0], 0);
    checkOutput("addu wdata2", wdataO[0], 5);
    checkIdleBus(0, "addu2");

    resetAll(2);
    applyStimulus(OP_LW, 32'h00000100, 32'h0, 5'd5, 1'b1, 32'h0, 32'h11112222);
    tick();
    tick();
    checkOutput("abort in access", ceNO[2], 0);
    rst = 1'b1;
    applyStimulus(OP_NOP, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("abort rst stall", stallO[2], 0);
    checkOutput("abort rst ram_addr", ramAddrO[2], 0);
    checkIdleBus(2, "abort rst");
    tick();
    rst = 1'b0;
    #1;
    checkOutput("abort idle stall", stallO[2], 0);
    checkOutput("abort idle ram_addr", ramAddrO[2], 0);
    checkOutput("abort idle wreg", wregO[2], 0);
    checkIdleBus(2, "abort idle");
    tick();
    checkOutput("abort no done wreg", wregO[2], 0);
    checkOutput("abort no done wdata", wdataO[2], 0);
    runAccess(2, OP_LW, 32'h00000100, 32'h0, 5'd5, 1'b1, 32'h0, 32'hA5A5F00F,
              32'hA5A5F00F, 4'h0, 20'h00040, 32'h0);
    applyStimulus(OP_NOP, 0, 0, 0, 0, 0, 0);
    tick();

    resetAll(1);
    runAccess(1, OP_SW, 32'h00000208, 32'hCAFEF00D, 5'd0, 1'b0, 32'h00000208, 32'h0,
              32'h00000208, 4'h0, 20'h00082, 32'hCAFEF00D);
    tick();
    runAccess(1, OP_LW, 32'h0000020C, 32'h0, 5'd9, 1'b1, 32'h0000020C, 32'h0BADBEEF,
              32'h0BADBEEF, 4'h0, 20'h00083, 32'h0);
    applyStimulus(OP_NOP, 0, 0, 0, 0, 0, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
